// File: rtl/fir_pkg.sv
// Shared constants and sample type for the FIR filter and its downstream stages.
package fir_pkg;
    localparam int FIR_W = 16;
    typedef logic [FIR_W-1:0] fir_sample_t;
endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous sample FIFO; occupancy counter drives full/empty, head shown combinationally.
module fir_sample_fifo
    import fir_pkg::*;
#(
    parameter int W     = FIR_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_req,
    input  logic [W-1:0]             wr_data,
    input  logic                     out_ready,
    output logic [W-1:0]             rd_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          vld_q;
    logic [W-1:0]  last_q;
    logic          do_pop, do_push, full;

    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = vld_q && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push_req && (!full || do_pop);
    assign drop    = push_req && !do_push;

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop)
            cnt_nxt = cnt + CW'(1);
        else if (!do_push && do_pop)
            cnt_nxt = cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld_q  <= 1'b0;
            last_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            cnt   <= cnt_nxt;
            vld_q <= (cnt_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr] <= wr_data;
    end

    // Once drained, the last popped sample stays on the output.
    assign rd_data   = vld_q ? mem[rd_ptr] : last_q;
    assign out_valid = vld_q;
    assign count     = cnt;
endmodule

// File: rtl/fir_decim_buffer.sv
// Keeps every M-th valid FIR sample and queues it for a valid/ready consumer.
module fir_decim_buffer
    import fir_pkg::*;
#(
    parameter int N     = FIR_W,
    parameter int M     = 4,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           data_in,
    input  logic                   in_valid,
    output logic [N-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam logic [PW-1:0] PH_MAX = PW'(M - 1);

    logic [PW-1:0] phase;
    logic          keep, drop;

    assign keep = in_valid && (phase == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid)
                phase <= (phase == PH_MAX) ? '0 : phase + PW'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end

    fir_sample_fifo #(.W(N), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_req  (keep),
        .wr_data   (data_in),
        .out_ready (out_ready),
        .rd_data   (out_data),
        .out_valid (out_valid),
        .count     (count),
        .drop      (drop)
    );
endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench: one M=4 instance and one M=1 instance, both DEPTH=8.
module tb_fir_decim_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst4, v4, r4, ov4, of4;
    logic [15:0] d4, o4;
    logic [3:0]  c4;
    logic        rst1, v1, r1, ov1, of1;
    logic [15:0] d1, o1;
    logic [3:0]  c1;

    int total = 0;
    int passed = 0;

    fir_decim_buffer #(.N(16), .M(4), .DEPTH(8)) u4 (
        .clk(clk), .reset(rst4), .data_in(d4), .in_valid(v4), .out_data(o4),
        .out_valid(ov4), .out_ready(r4), .count(c4), .overflow(of4));

    fir_decim_buffer #(.N(16), .M(1), .DEPTH(8)) u1 (
        .clk(clk), .reset(rst1), .data_in(d1), .in_valid(v1), .out_data(o1),
        .out_valid(ov1), .out_ready(r1), .count(c1), .overflow(of1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst4 = 1; rst1 = 1;
        v4 = 1; d4 = 16'h1234; r4 = 0;
        v1 = 1; d1 = 16'h1234; r1 = 0;
        for (int i = 0; i < 2; i++) begin
            tick;
            total++;
            if ({ov4, c4, o4, of4} !== {1'b0, 4'd0, 16'h0, 1'b0})
                $display("FAIL reset_m4 cyc%0d: got v=%b c=%0d d=%h o=%b want 0/0/0000/0", i, ov4, c4, o4, of4);
            else passed++;
            total++;
            if ({ov1, c1, o1, of1} !== {1'b0, 4'd0, 16'h0, 1'b0})
                $display("FAIL reset_m1 cyc%0d: got v=%b c=%0d d=%h o=%b want 0/0/0000/0", i, ov1, c1, o1, of1);
            else passed++;
        end
        v4 = 0; v1 = 0;
        rst4 = 0; rst1 = 0;
        tick;
    endtask

    task automatic test_decimation;
        logic       ev;
        logic [3:0] ec;
        r4 = 1; v4 = 1;
        for (int i = 1; i <= 12; i++) begin
            d4 = 16'(i);
            tick;
            ev = ((i - 1) % 4 == 0);
            ec = ev ? 4'd1 : 4'd0;
            total++;
            if ({ov4, c4} !== {ev, ec})
                $display("FAIL decim s%0d: got v=%b c=%0d want v=%b c=%0d", i, ov4, c4, ev, ec);
            else passed++;
            if (ev) begin
                total++;
                if (o4 !== 16'(i))
                    $display("FAIL decim_data s%0d: got %h want %h", i, o4, 16'(i));
                else passed++;
            end
        end
        v4 = 0;
    endtask

    task automatic test_gapped;
        int          vp [9] = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
        int          ek [9] = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
        logic [15:0] ed [9] = '{16'd10, 0, 0, 0, 0, 0, 0, 16'd14, 0};
        logic [15:0] s = 16'd10;
        r4 = 1;
        for (int i = 0; i < 9; i++) begin
            v4 = (vp[i] != 0);
            d4 = s;
            if (vp[i] != 0) s++;
            tick;
            total++;
            if (ov4 !== (ek[i] != 0))
                $display("FAIL gapped_valid cyc%0d: got %b want %b", i, ov4, ek[i] != 0);
            else passed++;
            if (ek[i] != 0) begin
                total++;
                if (o4 !== ed[i])
                    $display("FAIL gapped_data cyc%0d: got %h want %h", i, o4, ed[i]);
                else passed++;
            end
        end
        v4 = 0;
    endtask

    task automatic test_fill_overflow;
        logic [3:0] ec;
        r1 = 0; v1 = 1;
        for (int i = 1; i <= 10; i++) begin
            d1 = 16'(i);
            tick;
            ec = (i >= 8) ? 4'd8 : 4'(i);
            total++;
            if ({c1, of1} !== {ec, i >= 9})
                $display("FAIL fill s%0d: got c=%0d o=%b want c=%0d o=%b", i, c1, of1, ec, i >= 9);
            else passed++;
        end
        v1 = 0; r1 = 1;
        for (int k = 1; k <= 8; k++) begin
            total++;
            if ({ov1, o1} !== {1'b1, 16'(k)})
                $display("FAIL drain_ovf #%0d: got v=%b d=%h want v=1 d=%h", k, ov1, o1, 16'(k));
            else passed++;
            tick;
        end
        total++;
        if ({ov1, c1, o1, of1} !== {1'b0, 4'd0, 16'd8, 1'b1})
            $display("FAIL drain_ovf_end: got v=%b c=%0d d=%h o=%b want 0/0/0008/1", ov1, c1, o1, of1);
        else passed++;
        r1 = 0;
    endtask

    task automatic test_full_push_pop;
        rst1 = 1; tick; rst1 = 0;
        r1 = 0; v1 = 1;
        for (int i = 1; i <= 8; i++) begin
            d1 = 16'(i);
            tick;
        end
        total++;
        if ({c1, of1, o1} !== {4'd8, 1'b0, 16'd1})
            $display("FAIL full_setup: got c=%0d o=%b d=%h want 8/0/0001", c1, of1, o1);
        else passed++;
        r1 = 1; d1 = 16'd9;
        tick;
        total++;
        if ({c1, of1, o1} !== {4'd8, 1'b0, 16'd2})
            $display("FAIL full_pushpop: got c=%0d o=%b d=%h want 8/0/0002", c1, of1, o1);
        else passed++;
        v1 = 0;
        for (int k = 2; k <= 9; k++) begin
            total++;
            if ({ov1, o1} !== {1'b1, 16'(k)})
                $display("FAIL drain_full #%0d: got v=%b d=%h want v=1 d=%h", k, ov1, o1, 16'(k));
            else passed++;
            tick;
        end
        total++;
        if ({ov1, c1, of1} !== {1'b0, 4'd0, 1'b0})
            $display("FAIL drain_full_end: got v=%b c=%0d o=%b want 0/0/0", ov1, c1, of1);
        else passed++;
        r1 = 0;
    endtask

    task automatic test_mid_reset;
        // Phase is 2 here; kept samples are 3,7,...,35 then 39 (9th and 10th dropped).
        r4 = 0; v4 = 1;
        for (int i = 1; i <= 39; i++) begin
            d4 = 16'(i);
            tick;
        end
        v4 = 0;
        total++;
        if ({c4, of4, o4} !== {4'd8, 1'b1, 16'd3})
            $display("FAIL midrst_fill: got c=%0d o=%b d=%h want 8/1/0003", c4, of4, o4);
        else passed++;
        r4 = 1;
        repeat (3) tick;
        r4 = 0;
        total++;
        if ({c4, of4, o4} !== {4'd5, 1'b1, 16'd15})
            $display("FAIL midrst_pre: got c=%0d o=%b d=%h want 5/1/000f", c4, of4, o4);
        else passed++;
        rst4 = 1; tick; rst4 = 0;
        total++;
        if ({ov4, c4, of4} !== {1'b0, 4'd0, 1'b0})
            $display("FAIL midrst_post: got v=%b c=%0d o=%b want 0/0/0", ov4, c4, of4);
        else passed++;
        v4 = 1; d4 = 16'hBEEF;
        tick;
        v4 = 0;
        total++;
        if ({ov4, c4, o4} !== {1'b1, 4'd1, 16'hBEEF})
            $display("FAIL midrst_keep: got v=%b c=%0d d=%h want 1/1/beef", ov4, c4, o4);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_decimation;
        test_gapped;
        test_fill_overflow;
        test_full_push_pop;
        test_mid_reset;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fir_decim_buffer.md
# fir_decim_buffer

Downstream stage of `FIR_Filter`. It takes the filter's 16-bit output stream, keeps every M-th sample, and queues the kept samples in a small synchronous FIFO. The FIFO drains through a valid/ready handshake to the consumer, which may be a DAC interface, UART framer or capture logic. Input samples are never back-pressured, because the FIR produces a sample every valid cycle. Samples that arrive while the FIFO is full are dropped and flagged.

## Interface
Parameters:
- `N`, 16, sample width; matches the FIR data width.
- `M`, 4, decimation factor; must be ≥ 1, and M = 1 passes every sample.
- `DEPTH`, 8, FIFO depth in samples; must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock, rising-edge.
- `reset` in 1: synchronous, active-high; sampled on the `clk` rising edge.
- `data_in` in N: FIR output sample.
- `in_valid` in 1: `data_in` is a new sample this cycle.
- `out_data` out N: FIFO head sample.
- `out_valid` out 1: `out_data` holds a queued sample.
- `out_ready` in 1: consumer takes `out_data` on an edge where `out_valid` and `out_ready` are both high.
- `count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky; at least one kept sample was dropped since reset.

## Operation
**Phase counter**
- Range 0..M-1; advances on each cycle with `in_valid`, and wraps from M-1 to 0.
- A sample is "kept" when `in_valid` is high and phase = 0.
- The first valid sample after reset is always kept.
- Cycles without `in_valid` do not advance the phase.

**Push**
- A kept sample is written at the tail if `count` < DEPTH, or if `count` = DEPTH and a pop happens in the same cycle.
- Otherwise the sample is discarded and `overflow` is set to 1. It stays 1 until reset.

**Pop**
- Occurs on an edge where `out_valid` and `out_ready` are both high; the head advances.
- Nothing pops when `out_valid` = 0, regardless of `out_ready`.

**Simultaneous events**
- Push and pop in the same cycle: `count` is unchanged.
- Push into an empty FIFO: the sample is visible on `out_data` next cycle.

**Outputs**
- `out_valid` = (`count` ≠ 0).
- `out_data` is always the current head. It holds stable while `out_valid` is high and `out_ready` is low.
- `out_data` keeps its last value when the FIFO is empty (0 after reset).

**Pointers**
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
- Full and empty are derived from `count`, not from pointer compare.

**Reset**
- Phase = 0, pointers = 0, `count` = 0, `out_valid` = 0, `out_data` = 0, `overflow` = 0.
- Any kept sample presented in the reset cycle is ignored, and queued contents are discarded.

**Data**
- Samples pass through unaltered (no arithmetic, no sign handling); width is N in and N out.

## Timing
- Latency: a sample kept at edge k appears on `out_data` with `out_valid` = 1 after edge k, when the FIFO was empty.
- With a non-empty FIFO, the sample's position in the queue determines when it appears.
- Sustained throughput: one kept sample per M valid input cycles. A consumer holding `out_ready` = 1 never lets `count` exceed 1.
- `count`, `out_valid` and `overflow` are registered; `out_data` is read from the registered array at the registered read pointer.
- No combinational path from `out_ready` to `out_valid`. The only combinational input-to-state path is `out_ready` into the full-with-pop push decision.

## Structure
- Shared package `fir_pkg`:
  - `FIR_W` = 16, the common sample width constant for `FIR_Filter` and this block.
  - Sample typedef `fir_sample_t` (logic [FIR_W-1:0]).
- Sub-module `fir_sample_fifo`: synchronous FIFO with push/pop/count.
- The top level holds only the phase counter, keep decision, and overflow flag.

## Test plan
1. **Reset:** hold `reset` 2 cycles with `in_valid` = 1 and `data_in` = 0x1234 → `out_valid` = 0, `count` = 0, `out_data` = 0, `overflow` = 0 throughout.
2. **Decimation:** M = 4, `out_ready` = 1, `in_valid` = 1, `data_in` = 1,2,3,…,12 → outputs 1, 5, 9 in order. Each appears the cycle after its input edge; `count` never exceeds 1.
3. **Gapped input:** M = 4, `in_valid` pattern 1,0,0,1,1,0,1,1,1 carrying samples 10..15 → kept samples are the 1st and 5th valid ones, i.e. 10 and 14.
4. **Fill and overflow:** M = 1, DEPTH = 8, `out_ready` = 0, push 0x0001..0x000A → `count` = 8 and `overflow` = 1 after the 9th sample. Draining then yields 0x0001..0x0008 exactly.
5. **Full with simultaneous push/pop:** M = 1, FIFO full of 1..8, `out_ready` = 1 for one cycle while pushing 9 → `count` stays 8, `overflow` stays 0, and draining yields 2..9.
6. **Mid-operation reset:** `count` = 5 and `overflow` = 1, then assert `reset` 1 cycle → next cycle `count` = 0, `out_valid` = 0, `overflow` = 0. The next valid sample is kept (phase restarted at 0).
